frame_header_parser: RTL and testbench
======================================

// Module: frame_header_parser
// PURPOSE
//  Moore FSM ahead of the payload/CRC stage on the received byte stream.
//  Finds preamble + SFD, captures destination MAC, source MAC and type/length.
//  Raises payload_enable, which gates the payload/CRC byte counter, for exactly
//  PAYLOAD_CRC_BYTES cycles, then returns to hunting for the next frame.
// PARAMETERS
//  PREAMBLE_LEN       7            minimum count of 0x55 bytes required before SFD
//  PAYLOAD_CRC_BYTES  50           payload_enable high time, in cycles (46 payload + 4 CRC)
//  LOCAL_MAC          48'h0200_0000_0001  station address used by the MAC filter
// PORTS
//  clock           in   1   rising-edge clock
//  reset           in   1   asynchronous, active-high; clears all state and outputs
//  data_in         in   8   received byte
//  data_valid      in   1   data_in holds a byte this cycle
//  payload_enable  out  1   high throughout PAYLOAD state; feeds downstream enable
//  dest_addr       out  48  captured destination MAC, first byte in [47:40]
//  src_addr        out  48  captured source MAC, first byte in [47:40]
//  eth_type        out  16  captured type/length, first byte in [15:8]
//  header_valid    out  1   1-cycle pulse: header complete and accepted
//  preamble_error  out  1   1-cycle pulse: bad or short preamble/SFD
//  addr_error      out  1   1-cycle pulse: destination rejected (MAC_FILTER_EN only)
//  frame_abort     out  1   1-cycle pulse: data_valid dropped after SFD
// BEHAVIOUR
//  - Reset: state=IDLE; all counters 0; all outputs 0, including captured fields.
//  - All outputs are registered. A byte is accepted on a rising edge with data_valid=1.
//  - IDLE:     0x55 -> PREAMBLE, pcnt=1. Any other byte is ignored.
//  - PREAMBLE: 0x55 -> pcnt+1, saturating at PREAMBLE_LEN.
//              0xD5 with pcnt>=PREAMBLE_LEN -> DEST, bcnt=0.
//              0xD5 with pcnt<PREAMBLE_LEN, or any other byte -> preamble_error, IDLE.
//              data_valid=0 stalls the FSM (no error).
//  - DEST/SRC: 6 bytes each, shifted in MSB-first. DEST->SRC->TYPE after bcnt=5.
//              New fields overwrite the old ones from the first DEST byte onward.
//  - TYPE:     2 bytes. On the 2nd byte: header_valid pulses, FSM -> PAYLOAD,
//              payload_enable goes 1 on the same edge (high while 1st payload byte is on data_in).
//  - PAYLOAD:  counts cycles, bcnt 0..PAYLOAD_CRC_BYTES-1. At the last count -> IDLE and
//              payload_enable goes 0, so it is high exactly PAYLOAD_CRC_BYTES cycles.
//              payload_enable always drops for >=1 cycle between frames so the downstream counter clears.
//  - Frames are contiguous after SFD. data_valid=0 in DEST/SRC/TYPE/PAYLOAD:
//    pulse frame_abort, go IDLE, payload_enable=0 next edge. Captured fields keep partial values.
//  - Error pulses are mutually exclusive. A 0x55 that causes an error is not reused as a preamble start.
//  - Reset asserted mid-frame: immediate IDLE, payload_enable=0; no error pulse.
//  - Counters: pcnt 3 bits min; bcnt wide enough for PAYLOAD_CRC_BYTES-1. No wrap in any state.
// CONFIGURATION
//  MAC_FILTER_EN defined:
//    after the 6th DEST byte, compare dest_addr to LOCAL_MAC and to 48'hFFFF_FFFF_FFFF.
//    On no match: addr_error pulses, FSM -> IDLE, no header_valid, payload_enable stays 0.
//  MAC_FILTER_EN undefined:
//    every destination is accepted; addr_error is tied to 0.
// TESTING
//  1. 7x55,D5, dst=LOCAL_MAC, src, type 0800, 50 bytes -> header_valid 1 cycle,
//     eth_type=16'h0800, payload_enable high exactly 50 cycles, then 0.
//  2. 5x55,D5 -> preamble_error pulses on the D5 edge; state IDLE; payload_enable never 1.
//  3. Valid frame with data_valid=0 for 1 cycle at payload byte 20 -> frame_abort pulses;
//     payload_enable 0 next cycle; a following good frame parses normally.
//  4. MAC_FILTER_EN, dst=02:00:00:00:00:99 -> addr_error pulses after 6th DEST byte, no payload_enable.
//     dst=FF:FF:FF:FF:FF:FF -> accepted. Without the macro, both are accepted.
//  5. Back-to-back good frames -> payload_enable low >=1 cycle between them; second header captured.
//  6. reset asserted during SRC bytes -> all outputs 0 asynchronously; after release, IDLE ignores non-0x55 bytes.

Source files
------------

// File: rtl/frame_header_parser.sv
// Receive-side Ethernet header parser: hunts preamble+SFD, captures DA/SA/type, then gates payload/CRC.
// Optional destination filter enabled by defining MAC_FILTER_EN (accepts LOCAL_MAC or broadcast only).
module frame_header_parser #(
  parameter int          PREAMBLE_LEN      = 7,
  parameter int          PAYLOAD_CRC_BYTES = 50,
  parameter logic [47:0] LOCAL_MAC         = 48'h0200_0000_0001
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        payload_enable,
  output logic [47:0] dest_addr,
  output logic [47:0] src_addr,
  output logic [15:0] eth_type,
  output logic        header_valid,
  output logic        preamble_error,
  output logic        addr_error,
  output logic        frame_abort,
  output logic [2:0]  dbg_state
);

  // data_valid is a pure valid qualifier with no ready: every byte presented with
  // data_valid=1 on a rising edge is consumed; once past SFD a missing byte is an abort.

  localparam int PW = ($clog2(PREAMBLE_LEN + 1) > 3) ? $clog2(PREAMBLE_LEN + 1) : 3;
  localparam int BW = ($clog2(PAYLOAD_CRC_BYTES) > 3) ? $clog2(PAYLOAD_CRC_BYTES) : 3;

  localparam logic [PW-1:0] PCNT_MAX       = PW'(PREAMBLE_LEN);
  localparam logic [BW-1:0] BCNT_PAY_LAST  = BW'(PAYLOAD_CRC_BYTES - 1);
  localparam logic [BW-1:0] BCNT_ADDR_LAST = BW'(5);
  localparam logic [BW-1:0] BCNT_TYPE_LAST = BW'(1);
  localparam logic [7:0]    SYM_PRE        = 8'h55;
  localparam logic [7:0]    SYM_SFD        = 8'hD5;

`ifdef MAC_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_DEST     = 3'd2,
    S_SRC      = 3'd3,
    S_TYPE     = 3'd4,
    S_PAYLOAD  = 3'd5
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_pcnt;
  logic [BW-1:0] r_bcnt;
  logic [47:0]   r_dest;
  logic [47:0]   r_src;
  logic [15:0]   r_type;
  logic          r_pe;
  logic          r_hv;
  logic          r_perr;
  logic          r_aerr;
  logic          r_abort;

  state_t        w_state_nxt;
  logic [PW-1:0] w_pcnt_nxt;
  logic [BW-1:0] w_bcnt_nxt;
  logic [47:0]   w_dest_nxt;
  logic [47:0]   w_src_nxt;
  logic [15:0]   w_type_nxt;
  logic          w_pe_nxt;
  logic          w_hv_nxt;
  logic          w_perr_nxt;
  logic          w_aerr_nxt;
  logic          w_abort_nxt;

  logic [47:0]   w_dest_shift;
  logic [47:0]   w_src_shift;
  logic [15:0]   w_type_shift;
  logic          w_first;
  logic          w_dest_ok;

  // Each field restarts from zero on its own first byte, then shifts MSB-first.
  assign w_first      = (r_bcnt == '0);
  assign w_dest_shift = w_first ? {40'h0, data_in} : {r_dest[39:0], data_in};
  assign w_src_shift  = w_first ? {40'h0, data_in} : {r_src[39:0], data_in};
  assign w_type_shift = w_first ? {8'h0, data_in}  : {r_type[7:0], data_in};
  assign w_dest_ok    = !FILTER_EN || (w_dest_shift == LOCAL_MAC) || (w_dest_shift == 48'hFFFF_FFFF_FFFF);

  always_comb begin
    w_state_nxt = r_state;
    w_pcnt_nxt  = r_pcnt;
    w_bcnt_nxt  = r_bcnt;
    w_dest_nxt  = r_dest;
    w_src_nxt   = r_src;
    w_type_nxt  = r_type;
    w_hv_nxt    = 1'b0;
    w_perr_nxt  = 1'b0;
    w_aerr_nxt  = 1'b0;
    w_abort_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (data_valid && (data_in == SYM_PRE)) begin
          w_state_nxt = S_PREAMBLE;
          w_pcnt_nxt  = PW'(1);
        end
      end
      S_PREAMBLE: begin
        if (data_valid) begin
          if (data_in == SYM_PRE) begin
            if (r_pcnt < PCNT_MAX) w_pcnt_nxt = r_pcnt + PW'(1);
          end else if ((data_in == SYM_SFD) && (r_pcnt >= PCNT_MAX)) begin
            w_state_nxt = S_DEST;
            w_pcnt_nxt  = '0;
            w_bcnt_nxt  = '0;
          end else begin
            w_state_nxt = S_IDLE;
            w_pcnt_nxt  = '0;
            w_perr_nxt  = 1'b1;
          end
        end
      end
      S_DEST, S_SRC, S_TYPE, S_PAYLOAD: begin
        if (!data_valid) begin
          w_state_nxt = S_IDLE;
          w_bcnt_nxt  = '0;
          w_abort_nxt = 1'b1;
        end else if (r_state == S_DEST) begin
          w_dest_nxt = w_dest_shift;
          if (r_bcnt == BCNT_ADDR_LAST) begin
            w_bcnt_nxt = '0;
            if (w_dest_ok) begin
              w_state_nxt = S_SRC;
            end else begin
              w_state_nxt = S_IDLE;
              w_aerr_nxt  = 1'b1;
            end
          end else begin
            w_bcnt_nxt = r_bcnt + BW'(1);
          end
        end else if (r_state == S_SRC) begin
          w_src_nxt = w_src_shift;
          if (r_bcnt == BCNT_ADDR_LAST) begin
            w_bcnt_nxt  = '0;
            w_state_nxt = S_TYPE;
          end else begin
            w_bcnt_nxt = r_bcnt + BW'(1);
          end
        end else if (r_state == S_TYPE) begin
          w_type_nxt = w_type_shift;
          if (r_bcnt == BCNT_TYPE_LAST) begin
            w_bcnt_nxt  = '0;
            w_state_nxt = S_PAYLOAD;
            w_hv_nxt    = 1'b1;
          end else begin
            w_bcnt_nxt = r_bcnt + BW'(1);
          end
        end else begin
          if (r_bcnt == BCNT_PAY_LAST) begin
            w_bcnt_nxt  = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_bcnt_nxt = r_bcnt + BW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_pcnt_nxt  = '0;
        w_bcnt_nxt  = '0;
      end
    endcase
    // Registering the decode of the next state keeps payload_enable aligned with PAYLOAD.
    w_pe_nxt = (w_state_nxt == S_PAYLOAD);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pcnt  <= '0;
      r_bcnt  <= '0;
      r_dest  <= '0;
      r_src   <= '0;
      r_type  <= '0;
      r_pe    <= 1'b0;
      r_hv    <= 1'b0;
      r_perr  <= 1'b0;
      r_aerr  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_dest  <= w_dest_nxt;
      r_src   <= w_src_nxt;
      r_type  <= w_type_nxt;
      r_pe    <= w_pe_nxt;
      r_hv    <= w_hv_nxt;
      r_perr  <= w_perr_nxt;
      r_aerr  <= w_aerr_nxt;
      r_abort <= w_abort_nxt;
    end
  end

  assign payload_enable = r_pe;
  assign dest_addr      = r_dest;
  assign src_addr       = r_src;
  assign eth_type       = r_type;
  assign header_valid   = r_hv;
  assign preamble_error = r_perr;
  assign addr_error     = r_aerr;
  assign frame_abort    = r_abort;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_frame_header_parser.sv
// Bench for frame_header_parser: scenario tasks plus a negedge scoreboard for headers and payload_enable runs.
`timescale 1ns/1ps
module tb_frame_header_parser;

  localparam logic [47:0] LOCAL_MAC = 48'h0200_0000_0001;
  localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC_A     = 48'hA0A1_A2A3_A4A5;
  localparam logic [47:0] SRC_B     = 48'h0A0B_0C0D_0E0F;
  localparam int          NPAY      = 50;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic        data_valid = 1'b0;
  logic        payload_enable;
  logic [47:0] dest_addr;
  logic [47:0] src_addr;
  logic [15:0] eth_type;
  logic        header_valid;
  logic        preamble_error;
  logic        addr_error;
  logic        frame_abort;
  logic [2:0]  dbg_state;

  frame_header_parser dut (
    .clock          (clock),
    .reset          (reset),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .payload_enable (payload_enable),
    .dest_addr      (dest_addr),
    .src_addr       (src_addr),
    .eth_type       (eth_type),
    .header_valid   (header_valid),
    .preamble_error (preamble_error),
    .addr_error     (addr_error),
    .frame_abort    (frame_abort),
    .dbg_state      (dbg_state)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [111:0] exp_q[$];
  int           len_q[$];
  logic [111:0] mon_exp;
  int           mon_len;
  int           run_len   = 0;
  int           perr_cnt  = 0;
  int           aerr_cnt  = 0;
  int           abort_cnt = 0;

  // Scoreboard: headers and payload_enable run lengths are checked against queued expectations.
  always @(negedge clock) begin
    if (header_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL header_unexpected got=%h", {dest_addr, src_addr, eth_type});
      end else begin
        mon_exp = exp_q.pop_front();
        if ({dest_addr, src_addr, eth_type} !== mon_exp) begin
          bad++;
          $display("FAIL header_fields got=%h exp=%h", {dest_addr, src_addr, eth_type}, mon_exp);
        end
      end
    end
    if (payload_enable === 1'b1) begin
      run_len++;
    end else if (run_len != 0) begin
      total++;
      if (len_q.size() == 0) begin
        bad++;
        $display("FAIL payload_run_unexpected got=%0d", run_len);
      end else begin
        mon_len = len_q.pop_front();
        if (run_len != mon_len) begin
          bad++;
          $display("FAIL payload_run_len got=%0d exp=%0d", run_len, mon_len);
        end
      end
      run_len = 0;
    end
    if (preamble_error === 1'b1) perr_cnt++;
    if (addr_error === 1'b1)     aerr_cnt++;
    if (frame_abort === 1'b1)    abort_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    data_in    = b;
    data_valid = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic send_gap(input int n);
    data_in    = 8'h00;
    data_valid = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Payload bytes stay below 0x55 so a rejected frame's tail cannot start a preamble in IDLE.
  task automatic send_frame(input int npre, input logic [47:0] dst, input logic [47:0] src,
                            input logic [15:0] typ, input bit expect_hdr, input int abort_at);
    if (expect_hdr) begin
      exp_q.push_back({dst, src, typ});
      len_q.push_back((abort_at >= 0) ? abort_at + 1 : NPAY);
    end
    repeat (npre) send_byte(8'h55);
    send_byte(8'hD5);
    for (int i = 5; i >= 0; i--) send_byte(dst[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) send_byte(src[i*8 +: 8]);
    send_byte(typ[15:8]);
    send_byte(typ[7:0]);
    for (int i = 0; i < NPAY; i++) begin
      if (i == abort_at) begin
        send_gap(1);
        return;
      end
      send_byte(8'($urandom_range(0, 84)));
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    data_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if (payload_enable !== 1'b0) begin bad++; $display("FAIL reset_pe got=%b exp=0", payload_enable); end
    total++;
    if (dest_addr !== 48'h0) begin bad++; $display("FAIL reset_dest got=%h exp=0", dest_addr); end
    total++;
    if (src_addr !== 48'h0) begin bad++; $display("FAIL reset_src got=%h exp=0", src_addr); end
    total++;
    if (eth_type !== 16'h0) begin bad++; $display("FAIL reset_type got=%h exp=0", eth_type); end
    total++;
    if ({header_valid, preamble_error, addr_error, frame_abort} !== 4'b0) begin
      bad++;
      $display("FAIL reset_pulses got=%b exp=0000", {header_valid, preamble_error, addr_error, frame_abort});
    end
    total++;
    if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    reset = 1'b0;
    send_gap(2);
  endtask

  task automatic test_good_frame();
    send_frame(7, LOCAL_MAC, SRC_A, 16'h0800, 1'b1, -1);
    send_gap(3);
    total++;
    if (eth_type !== 16'h0800) begin bad++; $display("FAIL good_type got=%h exp=0800", eth_type); end
    total++;
    if (payload_enable !== 1'b0) begin bad++; $display("FAIL good_pe_after got=%b exp=0", payload_enable); end
    total++;
    if (dbg_state !== 3'd0) begin bad++; $display("FAIL good_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_preamble_errors();
    int p0;
    p0 = perr_cnt;
    repeat (5) send_byte(8'h55);
    send_byte(8'hD5);
    total++;
    if (preamble_error !== 1'b1) begin bad++; $display("FAIL short_pre_pulse got=%b exp=1", preamble_error); end
    total++;
    if (dbg_state !== 3'd0) begin bad++; $display("FAIL short_pre_state got=%0d exp=0", dbg_state); end
    send_gap(1);
    total++;
    if (preamble_error !== 1'b0) begin bad++; $display("FAIL short_pre_width got=%b exp=0", preamble_error); end
    repeat (7) send_byte(8'h55);
    send_byte(8'h12);
    send_gap(2);
    total++;
    if (perr_cnt - p0 != 2) begin bad++; $display("FAIL pre_err_count got=%0d exp=2", perr_cnt - p0); end
    // Long, stalled preamble: pcnt saturates and gaps before SFD are not errors.
    repeat (4) send_byte(8'h55);
    send_gap(2);
    send_frame(6, BCAST, SRC_B, 16'h0806, 1'b1, -1);
    send_gap(2);
    total++;
    if (perr_cnt - p0 != 2) begin bad++; $display("FAIL stall_pre_err got=%0d exp=2", perr_cnt - p0); end
  endtask

  task automatic test_abort();
    int a0;
    a0 = abort_cnt;
    send_frame(7, LOCAL_MAC, SRC_B, 16'h0806, 1'b1, 20);
    total++;
    if (frame_abort !== 1'b1) begin bad++; $display("FAIL abort_pulse got=%b exp=1", frame_abort); end
    total++;
    if (payload_enable !== 1'b0) begin bad++; $display("FAIL abort_pe got=%b exp=0", payload_enable); end
    total++;
    if (dbg_state !== 3'd0) begin bad++; $display("FAIL abort_state got=%0d exp=0", dbg_state); end
    send_gap(2);
    repeat (7) send_byte(8'h55);
    send_byte(8'hD5);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 84)));
    send_gap(2);
    total++;
    if (abort_cnt - a0 != 2) begin bad++; $display("FAIL abort_count got=%0d exp=2", abort_cnt - a0); end
    send_frame(7, LOCAL_MAC, SRC_A, 16'h88CC, 1'b1, -1);
    send_gap(2);
    total++;
    if (eth_type !== 16'h88CC) begin bad++; $display("FAIL abort_next_type got=%h exp=88cc", eth_type); end
  endtask

  task automatic test_mac_filter();
    int     e0;
    int     exp_aerr;
    bit     filt;
`ifdef MAC_FILTER_EN
    filt = 1'b1;
`else
    filt = 1'b0;
`endif
    exp_aerr = filt ? 1 : 0;
    e0 = aerr_cnt;
    send_frame(7, 48'h0200_0000_0099, SRC_A, 16'h0800, !filt, -1);
    send_gap(3);
    total++;
    if (aerr_cnt - e0 != exp_aerr) begin bad++; $display("FAIL mac_reject_aerr got=%0d exp=%0d", aerr_cnt - e0, exp_aerr); end
    total++;
    if (dest_addr !== 48'h0200_0000_0099) begin bad++; $display("FAIL mac_reject_dest got=%h exp=020000000099", dest_addr); end
    send_frame(7, BCAST, SRC_B, 16'h0800, 1'b1, -1);
    send_gap(3);
    total++;
    if (aerr_cnt - e0 != exp_aerr) begin bad++; $display("FAIL mac_bcast_aerr got=%0d exp=%0d", aerr_cnt - e0, exp_aerr); end
  endtask

  task automatic test_back_to_back();
    send_frame(7, LOCAL_MAC, SRC_A, 16'h0800, 1'b1, -1);
    send_frame(7, BCAST, SRC_B, 16'h86DD, 1'b1, -1);
    send_gap(3);
    total++;
    if ({dest_addr, src_addr, eth_type} !== {BCAST, SRC_B, 16'h86DD}) begin
      bad++;
      $display("FAIL b2b_second_hdr got=%h exp=%h", {dest_addr, src_addr, eth_type}, {BCAST, SRC_B, 16'h86DD});
    end
  endtask

  task automatic test_reset_mid_frame();
    int p0;
    repeat (7) send_byte(8'h55);
    send_byte(8'hD5);
    for (int i = 5; i >= 0; i--) send_byte(LOCAL_MAC[i*8 +: 8]);
    for (int i = 5; i >= 3; i--) send_byte(SRC_A[i*8 +: 8]);
    data_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({dest_addr, src_addr, eth_type} !== 112'h0) begin
      bad++;
      $display("FAIL async_reset_fields got=%h exp=0", {dest_addr, src_addr, eth_type});
    end
    total++;
    if ({payload_enable, header_valid, preamble_error, addr_error, frame_abort} !== 5'b0) begin
      bad++;
      $display("FAIL async_reset_flags got=%b exp=00000", {payload_enable, header_valid, preamble_error, addr_error, frame_abort});
    end
    total++;
    if (dbg_state !== 3'd0) begin bad++; $display("FAIL async_reset_state got=%0d exp=0", dbg_state); end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    p0 = perr_cnt;
    send_byte(8'hD5);
    send_byte(8'hAA);
    send_byte(8'h00);
    total++;
    if (dbg_state !== 3'd0) begin bad++; $display("FAIL idle_ignore_state got=%0d exp=0", dbg_state); end
    send_gap(1);
    total++;
    if (perr_cnt != p0) begin bad++; $display("FAIL idle_ignore_err got=%0d exp=%0d", perr_cnt, p0); end
    send_frame(7, LOCAL_MAC, SRC_B, 16'h0800, 1'b1, -1);
    send_gap(3);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_preamble_errors();
    test_abort();
    test_mac_filter();
    test_back_to_back();
    test_reset_mid_frame();
    send_gap(5);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL hdr_queue_left got=%0d exp=0", exp_q.size()); end
    total++;
    if (len_q.size() != 0) begin bad++; $display("FAIL len_queue_left got=%0d exp=0", len_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
